chien_search_par: RTL and testbench



---
 rtl/chien_search_par_pkg.sv | 47 ++++
 rtl/chien_search_par_gf_mul_const_m.sv | 20 ++
 rtl/chien_search_par.sv | 182 ++++++++++++++++++
 tb/tb_chien_search_par.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chien_search_par_pkg.sv
// Shared definitions for the parallel Chien search.
// Contents:
//   state_t       - search controller states
//   N             - number of evaluation points for the default field (M=6)
//   gf_mul_const  - GF(2^m) multiply of a by c, reduced by poly (m <= 16)
//   gf_alpha_pow  - alpha^e in GF(2^m), used to elaborate constant multipliers
package chien_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int M_DEF = 6;
  localparam int N     = (1 << M_DEF) - 1;

  // Shift-and-add multiply, MSB of c first. When c is an elaboration-time
  // constant this collapses to a fixed XOR network.
  function automatic logic [15:0] gf_mul_const(input logic [15:0] a,
                                               input logic [15:0] c,
                                               input int          m,
                                               input logic [16:0] poly);
    logic [16:0] acc;
    acc = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i < m) begin
        acc = acc << 1;
        if (acc[m]) acc = acc ^ poly;
        if (c[i]) acc = acc ^ {1'b0, a};
      end
    end
    return acc[15:0];
  endfunction

  function automatic logic [15:0] gf_alpha_pow(input int          e,
                                               input int          m,
                                               input logic [16:0] poly);
    logic [15:0] r;
    int          ee;
    r  = 16'd1;
    ee = e % ((1 << m) - 1);
    for (int i = 0; i < ee; i++) r = gf_mul_const(r, 16'd2, m, poly);
    return r;
  endfunction

endpackage

// File: rtl/chien_search_par_gf_mul_const_m.sv
// Combinational multiply of an M-bit field element by the constant alpha^E.
// Ports:
//   i_a - M-bit input element
//   o_y - i_a * alpha^E in GF(2^M) defined by PRIM_POLY
module gf_mul_const_m
  import chien_pkg::*;
#(
  parameter int         M         = 6,
  parameter logic [M:0] PRIM_POLY = 7'b1000011,
  parameter int         E         = 0
) (
  input  logic [M-1:0] i_a,
  output logic [M-1:0] o_y
);

  localparam logic [15:0] C = gf_alpha_pow(E, M, 17'(PRIM_POLY));

  assign o_y = M'(gf_mul_const(16'(i_a), C, M, 17'(PRIM_POLY)));

endmodule

// File: rtl/chien_search_par.sv
// Parallel Chien search: evaluates the locator Lambda(x) at alpha^0..alpha^(N-1),
// PAR points per cycle, and reports roots, root count, degree and a fail flag.
// Ports:
//   clk, resetN    - clock, synchronous active-low reset
//   start          - rising edge requests a search (ignored while busy)
//   lambda         - T+1 coefficients, lambda_0 in the LSBs
//   busy           - search in progress
//   finishFlag     - results valid, held until the next accepted start
//   errorPosition  - bit k set iff Lambda(alpha^k) == 0; top bit always 0
//   errCount       - number of roots found (saturates at T)
//   degree         - index of the highest nonzero coefficient
//   fail           - errCount != degree, Lambda all zero, or root overflow
module chien_search_par
  import chien_pkg::*;
#(
  parameter int         M          = 6,
  parameter int         T          = 8,
  parameter logic [M:0] PRIM_POLY  = 7'b1000011,
  parameter int         PAR        = 1,
  parameter int         EARLY_STOP = 0
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   start,
  input  logic [(T+1)*M-1:0]     lambda,
  output logic                   busy,
  output logic                   finishFlag,
  output logic [(1<<M)-1:0]      errorPosition,
  output logic [$clog2(T+1):0]   errCount,
  output logic [$clog2(T+1):0]   degree,
  output logic                   fail
);

  localparam int NPTS  = (1 << M) - 1;
  localparam int NSTEP = (NPTS + PAR - 1) / PAR;
  localparam int SW    = $clog2(NSTEP + 1);
  localparam int CW    = $clog2(T + 1) + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  state_t          r_state, w_state_nxt;
  logic            r_start_d, r_armed;
  logic            r_busy, r_finish, r_fail, r_ovf, r_allzero;
  logic [NPTS:0]   r_errpos, w_pos_nxt;
  logic [CW-1:0]   r_errcnt, w_cnt_nxt, r_degree, w_deg_in;
  logic            w_ovf_nxt, w_lam_zero, w_start_edge;
  logic [SW-1:0]   r_step;
  logic [M-1:0]    r_lam   [T+1];
  logic [M-1:0]    w_upd   [T+1];
  logic [M-1:0]    w_term  [PAR][T+1];
  logic [M-1:0]    w_v     [PAR];

  // r_armed blocks a start that was already high when reset was released.
  assign w_start_edge = start & ~r_start_d & r_armed;

  always_comb begin
    w_deg_in   = '0;
    w_lam_zero = 1'b1;
    for (int j = 0; j <= T; j++) begin
      if (lambda[j*M +: M] != '0) begin
        w_deg_in   = CW'(j);
        w_lam_zero = 1'b0;
      end
    end
  end

  // Evaluation taps: lambda_j * alpha^(j*p) for each parallel point p,
  // plus per-coefficient step update by alpha^(j*PAR).
  for (genvar p = 0; p < PAR; p++) begin : g_par
    for (genvar j = 0; j <= T; j++) begin : g_tap
      gf_mul_const_m #(.M(M), .PRIM_POLY(PRIM_POLY), .E(j*p)) u_mul (
        .i_a (r_lam[j]),
        .o_y (w_term[p][j])
      );
    end
  end

  for (genvar j = 0; j <= T; j++) begin : g_upd
    gf_mul_const_m #(.M(M), .PRIM_POLY(PRIM_POLY), .E(j*PAR)) u_mul (
      .i_a (r_lam[j]),
      .o_y (w_upd[j])
    );
  end

  always_comb begin
    for (int p = 0; p < PAR; p++) begin
      w_v[p] = '0;
      for (int j = 0; j <= T; j++) w_v[p] = w_v[p] ^ w_term[p][j];
    end
  end

  // Accumulate this cycle's roots; points past N-1 in the last step are masked.
  always_comb begin : p_count
    int k;
    k         = 0;
    w_pos_nxt = r_errpos;
    w_cnt_nxt = r_errcnt;
    w_ovf_nxt = r_ovf;
    for (int p = 0; p < PAR; p++) begin
      k = int'(r_step) * PAR + p;
      if (k < NPTS && w_v[p] == '0) begin
        w_pos_nxt[k] = 1'b1;
        if (w_cnt_nxt == CW'(T)) w_ovf_nxt = 1'b1;
        else                     w_cnt_nxt = w_cnt_nxt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_edge) w_state_nxt = w_lam_zero ? ST_FINISH : ST_SEARCH;
      ST_SEARCH: if (r_step == LAST_STEP ||
                     (EARLY_STOP != 0 && w_cnt_nxt == r_degree && r_degree != '0))
                   w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_start_d <= 1'b0;
      r_armed   <= ~start;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_fail    <= 1'b0;
      r_ovf     <= 1'b0;
      r_allzero <= 1'b0;
      r_errpos  <= '0;
      r_errcnt  <= '0;
      r_degree  <= '0;
      r_step    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= start;
      if (!start) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_start_edge) begin
          r_degree  <= w_deg_in;
          r_allzero <= w_lam_zero;
          r_errpos  <= '0;
          r_errcnt  <= '0;
          r_ovf     <= 1'b0;
          r_finish  <= 1'b0;
          r_fail    <= 1'b0;
          r_step    <= '0;
          r_busy    <= 1'b1;
        end
        ST_SEARCH: begin
          r_errpos <= w_pos_nxt;
          r_errcnt <= w_cnt_nxt;
          r_ovf    <= w_ovf_nxt;
          r_step   <= r_step + 1'b1;
        end
        ST_FINISH: begin
          r_fail   <= (r_errcnt != r_degree) | r_allzero | r_ovf;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Coefficient registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_start_edge) begin
      for (int j = 0; j <= T; j++) r_lam[j] <= lambda[j*M +: M];
    end else if (r_state == ST_SEARCH) begin
      for (int j = 0; j <= T; j++) r_lam[j] <= w_upd[j];
    end
  end

  assign busy          = r_busy;
  assign finishFlag    = r_finish;
  assign errorPosition = r_errpos;
  assign errCount      = r_errcnt;
  assign degree        = r_degree;
  assign fail          = r_fail;

endmodule

// File: tb/tb_chien_search_par.sv
// Scoreboard bench for chien_search_par: three instances (defaults, PAR=4,
// EARLY_STOP=1) share stimulus; a log/antilog field model predicts results.
module tb_chien_search_par;
  localparam int M  = 6;
  localparam int T  = 8;
  localparam int NP = 63;
  localparam int CW = 5;
  localparam int LW = (T + 1) * M;

  logic clk = 1'b0, resetN = 1'b0, start = 1'b0;
  logic [LW-1:0] lambda = '0;
  always #5 clk = ~clk;

  logic [2:0] busy, fin, fl;
  logic [63:0] ep0, ep1, ep2;
  logic [CW-1:0] cnt0, cnt1, cnt2, deg0, deg1, deg2;
  logic [2:0][63:0]   epv;
  logic [2:0][CW-1:0] cntv, degv;
  assign epv  = {ep2, ep1, ep0};
  assign cntv = {cnt2, cnt1, cnt0};
  assign degv = {deg2, deg1, deg0};

  chien_search_par u0 (.clk(clk), .resetN(resetN), .start(start), .lambda(lambda),
    .busy(busy[0]), .finishFlag(fin[0]), .errorPosition(ep0), .errCount(cnt0),
    .degree(deg0), .fail(fl[0]));
  chien_search_par #(.PAR(4)) u1 (.clk(clk), .resetN(resetN), .start(start), .lambda(lambda),
    .busy(busy[1]), .finishFlag(fin[1]), .errorPosition(ep1), .errCount(cnt1),
    .degree(deg1), .fail(fl[1]));
  chien_search_par #(.EARLY_STOP(1)) u2 (.clk(clk), .resetN(resetN), .start(start), .lambda(lambda),
    .busy(busy[2]), .finishFlag(fin[2]), .errorPosition(ep2), .errCount(cnt2),
    .degree(deg2), .fail(fl[2]));

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, npass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Field model: antilog/log tables.
  int alog[63];
  int lg[64];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 63];
  endfunction

  typedef struct {
    logic [63:0] ep;
    int          cnt;
    int          deg;
    bit          fl;
    bit          allzero;
    int          lastk;
    longint      sc;
  } exp_t;

  exp_t q[3][$];

  function automatic exp_t model(input logic [LW-1:0] lam);
    exp_t e;
    int c[T+1];
    int acc;
    bit ovf;
    e.ep = '0; e.cnt = 0; e.deg = 0; e.allzero = 1; e.lastk = -1; e.sc = 0; ovf = 0;
    for (int j = 0; j <= T; j++) begin
      c[j] = int'(lam[j*M +: M]);
      if (c[j] != 0) begin e.deg = j; e.allzero = 0; end
    end
    if (!e.allzero) begin
      for (int k = 0; k < NP; k++) begin
        acc = 0;
        for (int j = T; j >= 0; j--) acc = gmul(acc, alog[k]) ^ c[j];
        if (acc == 0) begin
          e.ep[k] = 1'b1;
          e.lastk = k;
          if (e.cnt == T) ovf = 1; else e.cnt++;
        end
      end
    end
    e.fl = e.allzero || (e.cnt != e.deg) || ovf;
    return e;
  endfunction

  function automatic logic [LW-1:0] prod_roots(input int r[$]);
    int p[T+1];
    logic [LW-1:0] v;
    for (int j = 0; j <= T; j++) p[j] = 0;
    p[0] = 1;
    foreach (r[i]) begin
      for (int j = T; j >= 1; j--) p[j] = p[j] ^ gmul(p[j-1], alog[r[i]]);
    end
    v = '0;
    for (int j = 0; j <= T; j++) v[j*M +: M] = M'(p[j]);
    return v;
  endfunction

  // Monitor: compare on each finishFlag rising edge.
  logic [2:0] fin_prev = '0;
  exp_t   mon_e;
  longint lat;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (fin[d] && !fin_prev[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("d%0d_unexpected_finish", d), 1, 0);
        end else begin
          mon_e = q[d].pop_front();
          lat   = cyc - mon_e.sc;
          chk($sformatf("d%0d_errpos", d), epv[d], mon_e.ep);
          chk($sformatf("d%0d_errcnt", d), 64'(cntv[d]), 64'(mon_e.cnt));
          chk($sformatf("d%0d_degree", d), 64'(degv[d]), 64'(mon_e.deg));
          chk($sformatf("d%0d_fail", d), 64'(fl[d]), 64'(mon_e.fl));
          chk($sformatf("d%0d_busy_done", d), 64'(busy[d]), 0);
          if (mon_e.allzero)
            chk($sformatf("d%0d_lat_zero", d), 64'(lat <= 2), 1);
          else if (d == 1)
            chk("d1_latency", 64'(lat), 17);
          else if (d == 2 && mon_e.deg > 0 && mon_e.cnt == mon_e.deg)
            chk("d2_early_latency", 64'(lat <= mon_e.lastk + 2), 1);
          else
            chk($sformatf("d%0d_latency", d), 64'(lat), 64);
        end
      end
      fin_prev[d] = fin[d];
    end
  end

  task automatic issue(input logic [LW-1:0] lam);
    exp_t e;
    e = model(lam);
    e.sc = cyc + 1;
    lambda = lam;
    start  = 1'b1;
    for (int d = 0; d < 3; d++) q[d].push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 150 && !done; i++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) done = 1;
    end
    if (!done) begin
      chk("timeout", 1, 0);
      for (int d = 0; d < 3; d++) q[d].delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int r[$];
    int nd, rv, jj;
    bit dup;
    logic [LW-1:0] lam;

    a = 1;
    for (int i = 0; i < 63; i++) begin
      alog[i] = a;
      lg[a]   = i;
      a = a << 1;
      if ((a & 64) != 0) a = a ^ 7'b1000011;
    end
    lg[0] = 0;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy%0d", d), 64'(busy[d]), 0);
      chk($sformatf("rst_fin%0d", d), 64'(fin[d]), 0);
      chk($sformatf("rst_ep%0d", d), epv[d], 0);
      chk($sformatf("rst_cnt%0d", d), 64'(cntv[d]), 0);
      chk($sformatf("rst_deg%0d", d), 64'(degv[d]), 0);
      chk($sformatf("rst_fail%0d", d), 64'(fl[d]), 0);
    end
    resetN = 1'b1;
    @(negedge clk);

    // 1 + x
    lam = '0; lam[0 +: M] = 1; lam[M +: M] = 1;
    issue(lam); wait_done();
    repeat (5) @(negedge clk);
    chk("hold_fin", 64'(fin[0]), 1);
    chk("hold_ep", ep0, 64'd1);

    // 1 + alpha^5 x
    lam = '0; lam[0 +: M] = 1; lam[M +: M] = M'(alog[5]);
    issue(lam); wait_done();

    // (1 + alpha^3 x)(1 + alpha^10 x)
    r = '{3, 10};
    issue(prod_roots(r)); wait_done();

    // 1 + x^2
    lam = '0; lam[0 +: M] = 1; lam[2*M +: M] = 1;
    issue(lam); wait_done();

    // all zero
    issue('0); wait_done();

    // degree 0, nonzero constant
    lam = '0; lam[0 +: M] = 6'd5;
    issue(lam); wait_done();

    // Abort with reset mid-search, start held high through release.
    r = '{7, 20, 41};
    issue(prod_roots(r));
    repeat (19) @(negedge clk);
    resetN = 1'b0;
    start  = 1'b1;
    for (int d = 0; d < 3; d++) q[d].delete();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_busy%0d", d), 64'(busy[d]), 0);
      chk($sformatf("abort_fin%0d", d), 64'(fin[d]), 0);
      chk($sformatf("abort_ep%0d", d), epv[d], 0);
      chk($sformatf("abort_cnt%0d", d), 64'(cntv[d]), 0);
    end
    resetN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("held_start_busy", 64'(busy), 0);
    end
    start = 1'b0;
    @(negedge clk);
    issue(prod_roots(r)); wait_done();

    // Second start edge during search is ignored.
    r = '{1, 33};
    issue(prod_roots(r));
    repeat (5) @(negedge clk);
    lambda = '0; lambda[0 +: M] = 1; lambda[M +: M] = 1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Randomized locators built from distinct roots, sometimes perturbed.
    for (int t = 0; t < 12; t++) begin
      nd = $urandom_range(0, T);
      r.delete();
      while (r.size() < nd) begin
        rv  = $urandom_range(0, 62);
        dup = 0;
        foreach (r[i]) if (r[i] == rv) dup = 1;
        if (!dup) r.push_back(rv);
      end
      lam = prod_roots(r);
      if ($urandom_range(0, 2) == 0) begin
        jj = $urandom_range(0, T);
        lam[jj*M +: M] = M'($urandom_range(0, 63));
      end
      issue(lam); wait_done();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
